// File: rtl/cdc_hs_tx_pkg.sv
// rtl/cdc_hs_tx_pkg.sv - shared state encoding, defaults and width helper for the req/ack sender
package cdc_hs_tx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_REL = 2'd2
  } hs_state_e;

  localparam int SYNC_DP_DEFAULT = 2;

  // Ceiling log2 that never returns 0, so a counter sized from it always has a bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/cdc_hs_tx_if.sv
// rtl/cdc_hs_tx_if.sv - local valid/ready word interface feeding the handshake sender
interface cdc_hs_tx_if #(
  parameter int DW = 32
);
  logic          tx_valid_i;
  logic          tx_ready_o;
  logic [DW-1:0] tx_data_i;

  modport master (output tx_valid_i, output tx_data_i, input tx_ready_o);
  modport slave  (input tx_valid_i, input tx_data_i, output tx_ready_o);
endinterface

// File: rtl/cdc_bit_sync.sv
// rtl/cdc_bit_sync.sv - single-bit multi-flop synchronizer, resets to 0
module cdc_bit_sync
  import cdc_hs_tx_pkg::*;
#(
  parameter int DEPTH = SYNC_DP_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// rtl/cdc_hs_tx.sv - sending end of a four-phase req/ack clock-domain-crossing handshake
module cdc_hs_tx
  import cdc_hs_tx_pkg::*;
#(
  parameter int DW      = 32,
  parameter int SYNC_DP = SYNC_DP_DEFAULT,
  parameter int TIMEOUT = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  cdc_hs_tx_if.slave    tx,
  output logic          req_o,
  output logic [DW-1:0] data_o,
  input  logic          ack_i,
  output logic          done_o,
  output logic          busy_o,
  output logic          timeout_o
);

  localparam int SW = clog2(SYNC_DP + 1);
  localparam int TW = clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SYNC_DP);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT);

  hs_state_e     state_q, state_d;
  logic          req_q, req_d;
  logic [DW-1:0] data_q, data_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;

  logic ack_s;
  logic settled;
  logic ready;

  cdc_bit_sync #(.DEPTH(SYNC_DP)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ack_i),
    .q_o   (ack_s)
  );

  // Ready stays low until the synchronizer has flushed its reset zeros and the peer's ack is low.
  assign settled = (settle_q == SETTLE_MAX);
  assign ready   = (state_q == IDLE) && settled && !ack_s;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    data_d     = data_q;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    settle_d   = settle_q;
    wait_cnt_d = wait_cnt_q;

    if (!settled) settle_d = settle_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (tx.tx_valid_i && ready) begin
          state_d = WAIT_ACK;
          req_d   = 1'b1;
          data_d  = tx.tx_data_i;
        end
      end
      WAIT_ACK: begin
        if (ack_s) begin
          state_d = WAIT_REL;
          req_d   = 1'b0;
        end
      end
      WAIT_REL: begin
        if (!ack_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    // The wait counter saturates; the flag is sticky and never aborts the protocol.
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (state_q != IDLE && wait_cnt_q != TO_MAX) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    if (TIMEOUT != 0 && state_q != IDLE && state_d == state_q && wait_cnt_d == TO_MAX) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      settle_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      data_q     <= data_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      settle_q   <= settle_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign tx.tx_ready_o = ready;
  assign req_o         = req_q;
  assign data_o        = data_q;
  assign done_o        = done_q;
  assign busy_o        = (state_q != IDLE);
  assign timeout_o     = timeout_q;

endmodule
